store_narrower: RTL

- Store-path counterpart of the load-side sign/zero extender: takes a 32-bit register value plus an access size and narrows it to byte, halfword or word stores on the 16-bit data memory bus.
- Word stores are split into two 16-bit beats; byte stores get lane steering and byte enables.
- Sits between the execute stage's store request and the memory bus arbiter.
- Misaligned requests are rejected with an error pulse and generate no bus traffic.

---
 rtl/store_narrower.sv | 105 ++++++++++
 1 files changed

// File: rtl/store_narrower.sv
// Store-path narrower: turns a 32-bit register store into byte, halfword or two-beat word
// transfers on a 16-bit data bus, rejecting misaligned or reserved-size requests.
module store_narrower #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [31:0]           reqData,
    input  logic [1:0]            reqSize,
    output logic                  busValid,
    input  logic                  busReady,
    output logic [ADDR_WIDTH-1:0] busAddr,
    output logic [15:0]           busData,
    output logic [1:0]            busByteEn,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;

    state_e                  state_q, state_d;
    logic                    accept;
    logic                    illegal;
    logic                    illegal_q;
    logic                    word_q;
    logic [15:0]             hi_q;
    logic [ADDR_WIDTH-1:0]   bus_addr_q;
    logic [15:0]             bus_data_q;
    logic [1:0]              bus_be_q;

    assign accept = reqValid & reqReady;

    always_comb begin
        illegal = 1'b0;
        unique case (reqSize)
            2'b00: illegal = 1'b0;
            2'b01: illegal = reqAddr[0];
            2'b10: illegal = |reqAddr[1:0];
            2'b11: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (reqValid) state_d = illegal ? StResp : StBeat0;
            StBeat0: if (busReady) state_d = word_q ? StBeat1 : StResp;
            StBeat1: if (busReady) state_d = StResp;
            StResp:  state_d = StIdle;
        endcase
    end

    always_comb begin
        reqReady  = (state_q == StIdle);
        busValid  = (state_q == StBeat0) || (state_q == StBeat1);
        done      = (state_q == StResp) && !illegal_q;
        err       = (state_q == StResp) && illegal_q;
        busAddr   = bus_addr_q;
        busData   = bus_data_q;
        busByteEn = bus_be_q;
    end

    // Payload is loaded at accept and only advanced on the first word beat's handshake,
    // so it holds steady through any bus stall.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            illegal_q  <= 1'b0;
            word_q     <= 1'b0;
            hi_q       <= '0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            bus_be_q   <= '0;
        end else if (accept) begin
            illegal_q <= illegal;
            word_q    <= (reqSize == 2'b10);
            hi_q      <= reqData[31:16];
            if (!illegal) begin
                if (reqSize == 2'b00) begin
                    bus_addr_q <= {reqAddr[ADDR_WIDTH-1:1], 1'b0};
                    bus_data_q <= {2{reqData[7:0]}};
                    bus_be_q   <= reqAddr[0] ? 2'b10 : 2'b01;
                end else begin
                    bus_addr_q <= reqAddr;
                    bus_data_q <= reqData[15:0];
                    bus_be_q   <= 2'b11;
                end
            end
        end else if ((state_q == StBeat0) && busReady && word_q) begin
            bus_addr_q <= bus_addr_q + ADDR_WIDTH'(2);
            bus_data_q <= hi_q;
        end
    end

endmodule
